// File: rtl/exec_trace_monitor.sv
// Execution trace monitor: snoops regfile write-back into a show-ahead trace FIFO and
// watches pc for halt / run-budget timeout. Define TRACE_PC_EN to store pc per entry.
module exec_trace_monitor #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 12,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4,
  parameter int TIMEOUT     = 100
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [PC_W-1:0]          pc,
  input  logic [2**ADDR_W-1:0]     watch_mask,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [PC_W-1:0]          rd_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     halted,
  output logic                     timed_out,
  output logic [31:0]              cycle_cnt
);

  // state   | meaning
  // IDLE    | waiting for en; trace buffer and overflow retained
  // RUN     | counting cycles, detecting halt, capturing write-backs
  // HALTED  | pc unchanged for HALT_CYCLES cycles; cycle_cnt frozen
  // TIMEOUT | run budget exhausted; cycle_cnt frozen
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HC_W  = $clog2(HALT_CYCLES + 1);

  state_t            state_q, state_nxt;
  logic [31:0]       cyc_q, cyc_nxt;
  logic [HC_W-1:0]   hcnt_q, hcnt_nxt;
  logic [PC_W-1:0]   prev_pc_q;
  logic              halt_hit;
  logic              to_hit;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      hcnt_q    <= '0;
      prev_pc_q <= '0;
    end else begin
      state_q   <= state_nxt;
      cyc_q     <= cyc_nxt;
      hcnt_q    <= hcnt_nxt;
      prev_pc_q <= pc;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cyc_nxt   = cyc_q;
    hcnt_nxt  = hcnt_q;
    halt_hit  = 1'b0;
    to_hit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_nxt = S_RUN;
          cyc_nxt   = '0;
          hcnt_nxt  = '0;
        end
      end
      S_RUN: begin
        if (cyc_q != '1) cyc_nxt = cyc_q + 32'd1;
        if (pc == prev_pc_q) hcnt_nxt = hcnt_q + HC_W'(1);
        else                 hcnt_nxt = '0;
        halt_hit = (pc == prev_pc_q) && (hcnt_q == HC_W'(HALT_CYCLES - 1));
        to_hit   = (cyc_q == 32'(TIMEOUT - 1));
        // halt takes priority when both qualify on the same edge
        if (halt_hit)    state_nxt = S_HALTED;
        else if (to_hit) state_nxt = S_TIMEOUT;
      end
      default: ;
    endcase
    if (!en) state_nxt = S_IDLE;
  end

  assign halted    = (state_q == S_HALTED);
  assign timed_out = (state_q == S_TIMEOUT);
  assign cycle_cnt = cyc_q;

  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              ovf_q;
  logic              capture, pop, push, full;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign rd_valid = (cnt_q != '0);
  assign capture  = (state_q == S_RUN) && wb_we && (wb_addr != '0) && watch_mask[wb_addr];
  assign pop      = rd_valid && rd_ready;
  assign push     = capture && (!full || pop);

  always_comb begin
    cnt_nxt = cnt_q;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt_q + CNT_W'(1);
      2'b01:   cnt_nxt = cnt_q - CNT_W'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (capture && full && !pop) ovf_q <= 1'b1;
    end
  end

  // storage carries no reset; reads are masked while empty
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_addr[wptr_q] <= wb_addr;
      mem_data[wptr_q] <= wb_data;
    end
  end

  assign rd_addr  = rd_valid ? mem_addr[rptr_q] : '0;
  assign rd_data  = rd_valid ? mem_data[rptr_q] : '0;
  assign count    = cnt_q;
  assign overflow = ovf_q;

`ifdef TRACE_PC_EN
  logic [PC_W-1:0] mem_pc [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (push) mem_pc[wptr_q] <= pc;
  end

  assign rd_pc = rd_valid ? mem_pc[rptr_q] : '0;
`else
  assign rd_pc = '0;
`endif

endmodule

// File: tb/tb_exec_trace_monitor.sv
// Directed self-checking bench for exec_trace_monitor (default parameters).
module tb_exec_trace_monitor;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [11:0] pc;
  logic [31:0] watch_mask;
  logic        rd_ready;
  logic        rd_valid;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [11:0] rd_pc;
  logic [4:0]  count;
  logic        overflow;
  logic        halted;
  logic        timed_out;
  logic [31:0] cycle_cnt;

  int nvec = 0;
  int nerr = 0;

  exec_trace_monitor dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .en        (en),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .pc        (pc),
    .watch_mask(watch_mask),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pc     (rd_pc),
    .count     (count),
    .overflow  (overflow),
    .halted    (halted),
    .timed_out (timed_out),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drv(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we   = we;
    wb_addr = a;
    wb_data = d;
  endtask

  function automatic logic [11:0] pcx(input logic [11:0] v);
`ifdef TRACE_PC_EN
    return v;
`else
    return 12'h000;
`endif
  endfunction

  initial begin
    logic [31:0] exp_d;
    rst_n = 1'b0; en = 1'b0; rd_ready = 1'b0; pc = '0; watch_mask = '0;
    drv(1'b0, 5'd0, 32'd0);
    #2;
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_timeout", timed_out, 1'b0);
    chk("rst_cyc", cycle_cnt, 32'd0);
    chk("rst_rd_addr", rd_addr, 5'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_pc", rd_pc, 12'd0);
    #10 rst_n = 1'b1;
    tick();

    // mask filtering, r0 exclusion, capture latency, pop
    watch_mask = 32'h0000_003E;
    pc = 12'h100; en = 1'b1;
    tick();
    pc = 12'h101; drv(1'b1, 5'd1, 32'd5); tick();
    chk("cap1_valid", rd_valid, 1'b1);
    chk("cap1_count", count, 5'd1);
    chk("cap1_addr", rd_addr, 5'd1);
    chk("cap1_data", rd_data, 32'd5);
    chk("cap1_pc", rd_pc, pcx(12'h101));
    pc = 12'h102; drv(1'b1, 5'd2, 32'd7); tick();
    pc = 12'h103; drv(1'b1, 5'd0, 32'd9); tick();
    pc = 12'h104; drv(1'b1, 5'd6, 32'd1); tick();
    drv(1'b0, 5'd0, 32'd0);
    chk("mask_count", count, 5'd2);
    chk("mask_cyc", cycle_cnt, 32'd4);
    chk("mask_head", rd_data, 32'd5);
    pc = 12'h105; rd_ready = 1'b1; tick();
    chk("pop1_count", count, 5'd1);
    chk("pop1_addr", rd_addr, 5'd2);
    chk("pop1_data", rd_data, 32'd7);
    chk("pop1_pc", rd_pc, pcx(12'h102));
    pc = 12'h106; tick();
    chk("pop2_valid", rd_valid, 1'b0);
    chk("pop2_data", rd_data, 32'd0);
    pc = 12'h107; tick();
    chk("pop_empty_count", count, 5'd0);
    rd_ready = 1'b0;
    en = 1'b0; tick();

    // halt after four cycles of unchanged pc
    pc = 12'h010; tick();
    en = 1'b1; tick();
    chk("halt_entry_cyc", cycle_cnt, 32'd0);
    tick(); tick(); tick();
    chk("halt_3", halted, 1'b0);
    tick();
    chk("halt_4", halted, 1'b1);
    chk("halt_cyc", cycle_cnt, 32'd4);
    tick(); tick();
    chk("halt_frozen", cycle_cnt, 32'd4);
    chk("halt_hold", halted, 1'b1);
    en = 1'b0; tick();
    chk("halt_exit", halted, 1'b0);
    chk("halt_exit_to", timed_out, 1'b0);

    // timeout after 100 run cycles
    pc = 12'h200; en = 1'b1; tick();
    chk("to_entry_cyc", cycle_cnt, 32'd0);
    for (int i = 0; i < 99; i++) begin
      pc = pc + 12'd1; tick();
    end
    chk("to_99_cyc", cycle_cnt, 32'd99);
    chk("to_99_flag", timed_out, 1'b0);
    pc = pc + 12'd1; tick();
    chk("to_100_flag", timed_out, 1'b1);
    chk("to_100_cyc", cycle_cnt, 32'd100);
    chk("to_100_halt", halted, 1'b0);
    pc = pc + 12'd1; tick();
    chk("to_frozen", cycle_cnt, 32'd100);
    en = 1'b0; tick();
    chk("to_exit", timed_out, 1'b0);

    // halt and timeout on the same edge: halt wins
    pc = 12'h300; en = 1'b1; tick();
    for (int i = 0; i < 96; i++) begin
      pc = pc + 12'd1; tick();
    end
    tick(); tick(); tick();
    chk("both_99_halt", halted, 1'b0);
    chk("both_99_cyc", cycle_cnt, 32'd99);
    tick();
    chk("both_halt", halted, 1'b1);
    chk("both_to", timed_out, 1'b0);
    chk("both_cyc", cycle_cnt, 32'd100);
    en = 1'b0; tick();

    // fill to full, overflow, push+pop while full, drain order
    watch_mask = 32'hFFFF_FFFE;
    pc = 12'h400; en = 1'b1; tick();
    for (int i = 0; i < 17; i++) begin
      pc = pc + 12'd1;
      drv(1'b1, 5'(i % 31 + 1), 32'h1000 + 32'(i));
      tick();
      if (i == 15) begin
        chk("fill16_count", count, 5'd16);
        chk("fill16_ovf", overflow, 1'b0);
      end
    end
    drv(1'b0, 5'd0, 32'd0);
    chk("ovf_count", count, 5'd16);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_head", rd_data, 32'h1000);
    pc = pc + 12'd1; drv(1'b1, 5'd9, 32'h2000); rd_ready = 1'b1; tick();
    drv(1'b0, 5'd0, 32'd0); rd_ready = 1'b0;
    chk("pp_count", count, 5'd16);
    chk("pp_ovf", overflow, 1'b1);
    chk("pp_head", rd_data, 32'h1001);
    en = 1'b0; tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 15) ? 32'h1001 + 32'(i) : 32'h2000;
      chk("drain_data", rd_data, exp_d);
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_count", count, 5'd0);
    chk("drain_ovf_kept", overflow, 1'b1);

    // reset mid-run with three entries
    en = 1'b1; tick();
    pc = 12'h020; drv(1'b1, 5'd3, 32'hAA); tick();
    pc = 12'h021; drv(1'b1, 5'd4, 32'hBB); tick();
    pc = 12'h022; drv(1'b1, 5'd5, 32'hCC); tick();
    pc = 12'h023; drv(1'b1, 5'd6, 32'hDD);
    chk("mr_count", count, 5'd3);
    chk("mr_addr", rd_addr, 5'd3);
    chk("mr_data", rd_data, 32'hAA);
    chk("mr_pc", rd_pc, pcx(12'h020));
    chk("mr_cyc", cycle_cnt, 32'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_count", count, 5'd0);
    chk("ar_valid", rd_valid, 1'b0);
    chk("ar_data", rd_data, 32'd0);
    chk("ar_addr", rd_addr, 5'd0);
    chk("ar_pc", rd_pc, 12'd0);
    chk("ar_cyc", cycle_cnt, 32'd0);
    chk("ar_ovf", overflow, 1'b0);
    tick();
    chk("ar_held_count", count, 5'd0);
    drv(1'b0, 5'd0, 32'd0); en = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_count", count, 5'd0);
    chk("post_rst_halt", halted, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/exec_trace_monitor.md
EXEC_TRACE_MONITOR -- requirements
Module: exec_trace_monitor

Interface
REQ-001 Parameter DATA_W, 32, width of register write-back data.
REQ-002 Parameter ADDR_W, 5, width of register index; 2**ADDR_W registers.
REQ-003 Parameter PC_W, 12, width of program counter.
REQ-004 Parameter DEPTH, 16, trace buffer entries; power of two, >=2.
REQ-005 Parameter HALT_CYCLES, 4, consecutive cycles of unchanged pc declaring halt.
REQ-006 Parameter TIMEOUT, 100, run-cycle budget before timeout.
REQ-007 clock  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-009 en  in  1  run enable.
REQ-010 wb_we, wb_addr, wb_data  in  1/ADDR_W/DATA_W  regfile write port snoop.
REQ-011 pc  in  PC_W  current processor PC.
REQ-012 watch_mask  in  2**ADDR_W  bit i set = capture writes to register i.
REQ-013 rd_ready  in  1  consumer pops head entry.
REQ-014 rd_valid  out  1  buffer non-empty.
REQ-015 rd_addr, rd_data, rd_pc  out  ADDR_W/DATA_W/PC_W  head entry (show-ahead).
REQ-016 count  out  clog2(DEPTH)+1  current occupancy.
REQ-017 overflow, halted, timed_out  out  1 each  sticky status.
REQ-018 cycle_cnt  out  32  cycles spent in RUN since last IDLE->RUN.

Function
REQ-019 FSM states IDLE, RUN, HALTED, TIMEOUT; halted=1 only in HALTED, timed_out=1 only in TIMEOUT.
REQ-020 IDLE->RUN when en=1; cycle_cnt and halt counter clear on that transition.
REQ-021 Any state ->IDLE on next edge when en=0; trace buffer contents and overflow retained.
REQ-022 RUN: cycle_cnt increments by 1 per cycle, saturating at 2**32-1.
REQ-023 RUN: halt counter increments when pc equals previous-cycle pc, clears otherwise; reaching HALT_CYCLES -> HALTED.
REQ-024 RUN: cycle_cnt reaching TIMEOUT-1 with a further RUN cycle -> TIMEOUT; if halt and timeout qualify same cycle, HALTED wins.
REQ-025 HALTED and TIMEOUT hold cycle_cnt frozen; exit only via en=0 or reset.
REQ-026 Capture only in RUN, when wb_we=1, wb_addr!=0, watch_mask[wb_addr]=1; entry = {pc, wb_addr, wb_data} of that cycle.
REQ-027 Pop when rd_valid=1 and rd_ready=1; rd_ready with empty buffer ignored.
REQ-028 Capture while full without simultaneous pop: entry dropped, overflow set to 1 (sticky until reset).
REQ-029 Capture and pop same cycle when full: both performed, count unchanged, overflow unchanged.
REQ-030 Pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-031 Pop operates in every FSM state; capture latency 1 cycle (entry visible on rd_* the cycle after the capture edge when previously empty).

Reset
REQ-032 On reset low: state IDLE, count=0, pointers=0, rd_valid=0, overflow=0, halted=0, timed_out=0, cycle_cnt=0, halt counter=0, previous-pc register=0.
REQ-033 rd_addr, rd_data, rd_pc SHALL read 0 while buffer empty after reset.
REQ-034 Reset asserted mid-RUN aborts immediately; no partial entry is stored.

Configuration
REQ-035 Macro TRACE_PC_EN defined: PC field stored per entry and driven on rd_pc.
REQ-036 TRACE_PC_EN undefined: no PC storage synthesised, rd_pc tied to 0; all other behaviour identical.

Verification
REQ-037 en=1, pc advances each cycle, watch_mask=32'h0000_003E, writes r1=5,r2=7,r0=9,r6=1 -> buffer holds (1,5),(2,7) only, count=2.
REQ-038 RUN with pc held at 12'h010 for 4 cycles -> halted=1 on 4th edge, cycle_cnt frozen, en=0 -> IDLE next edge, halted=0.
REQ-039 TIMEOUT=100, pc always changing -> timed_out=1 after 100 RUN cycles, cycle_cnt=100.
REQ-040 DEPTH=16, 17 captures, no pops -> count=16, overflow=1; 17th entry absent; then push+pop same cycle -> count stays 16.
REQ-041 Reset pulled low mid-RUN with count=3 -> all outputs zero immediately, state IDLE.
REQ-042 Build without TRACE_PC_EN, capture at pc=12'h020 -> rd_pc=0, rd_addr/rd_data correct.
